trap_sequencer: RTL and testbench



---
 rtl/trap_sequencer.sv | 129 ++++++++++++
 tb/tb_trap_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// trap_sequencer: sequences mepc/mcause/mstatus/mtvec CSR traffic for traps and MRET; define TRAP_SEQ_MTVAL_EN to also save mtval
module trap_sequencer #(
  parameter int XLEN = 32,
  parameter logic [1:0] MPP_M = 2'b11
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            exc_valid,
  input  logic [3:0]      exc_cause,
  input  logic [XLEN-1:0] exc_pc,
`ifdef TRAP_SEQ_MTVAL_EN
  input  logic [XLEN-1:0] exc_tval,
`endif
  input  logic            mret_valid,
  output logic            stall,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [11:0]     csr_addr,
  output logic            csr_read_en,
  output logic            csr_write_en,
  output logic [XLEN-1:0] csr_write_data,
  input  logic [XLEN-1:0] csr_read_data
);
  localparam logic [XLEN-1:0] ALIGN = {{(XLEN-2){1'b1}}, 2'b00};
  typedef enum logic [3:0] {
    IDLE, SAVE_EPC, SAVE_CAUSE, SET_STATUS, VECTOR, RET_STATUS, RET_PC, DONE
`ifdef TRAP_SEQ_MTVAL_EN
    , SAVE_TVAL
`endif
  } state_t;
  state_t          r_state, w_next;
  logic [XLEN-1:0] r_epc, r_redirect_pc;
  logic [3:0]      r_cause;
`ifdef TRAP_SEQ_MTVAL_EN
  logic [XLEN-1:0] r_tval;
`endif
  assign redirect_pc = r_redirect_pc;
  // Reset gates every output so a sequence caught mid-flight issues no further CSR traffic
  always_comb begin
    w_next = r_state;
    stall = !reset && (r_state != IDLE || exc_valid || mret_valid);
    redirect_valid = 1'b0;
    csr_addr = '0;
    csr_read_en = 1'b0;
    csr_write_en = 1'b0;
    csr_write_data = '0;
    if (!reset) begin
      case (r_state)
        IDLE: w_next = exc_valid ? SAVE_EPC : mret_valid ? RET_STATUS : IDLE;
        SAVE_EPC: begin
          csr_addr = 12'h341;
          csr_write_en = 1'b1;
          csr_write_data = r_epc & ALIGN;
          w_next = SAVE_CAUSE;
        end
        SAVE_CAUSE: begin
          csr_addr = 12'h342;
          csr_write_en = 1'b1;
          csr_write_data = {{(XLEN-4){1'b0}}, r_cause};
`ifdef TRAP_SEQ_MTVAL_EN
          w_next = SAVE_TVAL;
`else
          w_next = SET_STATUS;
`endif
        end
`ifdef TRAP_SEQ_MTVAL_EN
        SAVE_TVAL: begin
          csr_addr = 12'h343;
          csr_write_en = 1'b1;
          csr_write_data = r_tval;
          w_next = SET_STATUS;
        end
`endif
        SET_STATUS: begin
          csr_addr = 12'h300;
          csr_read_en = 1'b1;
          csr_write_en = 1'b1;
          csr_write_data = {csr_read_data[XLEN-1:13], MPP_M, csr_read_data[10:8],
                            csr_read_data[3], csr_read_data[6:4], 1'b0, csr_read_data[2:0]};
          w_next = VECTOR;
        end
        VECTOR: begin
          csr_addr = 12'h305;
          csr_read_en = 1'b1;
          w_next = DONE;
        end
        RET_STATUS: begin
          csr_addr = 12'h300;
          csr_read_en = 1'b1;
          csr_write_en = 1'b1;
          csr_write_data = {csr_read_data[XLEN-1:13], 2'b00, csr_read_data[10:8],
                            1'b1, csr_read_data[6:4], csr_read_data[7], csr_read_data[2:0]};
          w_next = RET_PC;
        end
        RET_PC: begin
          csr_addr = 12'h341;
          csr_read_en = 1'b1;
          w_next = DONE;
        end
        DONE: begin
          redirect_valid = 1'b1;
          w_next = IDLE;
        end
        default: w_next = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_epc <= '0;
      r_cause <= '0;
      r_redirect_pc <= '0;
`ifdef TRAP_SEQ_MTVAL_EN
      r_tval <= '0;
`endif
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && exc_valid) begin
        r_epc <= exc_pc;
        r_cause <= exc_cause;
`ifdef TRAP_SEQ_MTVAL_EN
        r_tval <= exc_tval;
`endif
      end
      if (r_state == VECTOR || r_state == RET_PC) r_redirect_pc <= csr_read_data & ALIGN;
    end
  end
endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: randomized trap/MRET traffic against a behavioural CSR-file and sequence model
module tb_trap_sequencer;
  logic        clk = 1'b0;
  logic        reset, exc_valid, mret_valid;
  logic [3:0]  exc_cause;
  logic [31:0] exc_pc;
`ifdef TRAP_SEQ_MTVAL_EN
  logic [31:0] exc_tval;
`endif
  logic        stall, redirect_valid, csr_read_en, csr_write_en;
  logic [31:0] redirect_pc, csr_write_data, csr_read_data;
  logic [11:0] csr_addr;
  logic [31:0] m_status, m_epc, m_cause, m_tval, m_tvec;
  logic [11:0] log_a[$];
  logic [31:0] log_d[$];
  int n_pass = 0, n_total = 0;
`ifdef TRAP_SEQ_MTVAL_EN
  localparam int EXC_LAT = 6;
`else
  localparam int EXC_LAT = 5;
`endif

  trap_sequencer dut (
    .clk(clk), .reset(reset), .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc),
`ifdef TRAP_SEQ_MTVAL_EN
    .exc_tval(exc_tval),
`endif
    .mret_valid(mret_valid), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .csr_addr(csr_addr), .csr_read_en(csr_read_en),
    .csr_write_en(csr_write_en), .csr_write_data(csr_write_data), .csr_read_data(csr_read_data)
  );

  always #5 clk = ~clk;

  always_comb
    csr_read_data = csr_addr == 12'h300 ? m_status : csr_addr == 12'h341 ? m_epc :
                    csr_addr == 12'h342 ? m_cause : csr_addr == 12'h343 ? m_tval :
                    csr_addr == 12'h305 ? m_tvec : 32'h0;

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation timeout");
  end

  function automatic logic [31:0] trap_status(input logic [31:0] s);
    return (s & ~32'h1888) | (((s >> 3) & 32'h1) << 7) | 32'h1800;
  endfunction

  function automatic logic [31:0] ret_status(input logic [31:0] s);
    return (s & ~32'h1888) | (((s >> 7) & 32'h1) << 3) | 32'h80;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    logic w;
    logic [11:0] a;
    logic [31:0] d;
    #1;
    w = csr_write_en;
    a = csr_addr;
    d = csr_write_data;
    if (w === 1'b1) begin
      log_a.push_back(a);
      log_d.push_back(d);
    end
    @(posedge clk);
    #1;
    if (w === 1'b1)
      case (a)
        12'h300: m_status = d;
        12'h341: m_epc = d;
        12'h342: m_cause = d;
        12'h343: m_tval = d;
        default: ;
      endcase
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_stall"}, 32'(stall), 0);
    chk({tag, "_rv"}, 32'(redirect_valid), 0);
    chk({tag, "_addr"}, 32'(csr_addr), 0);
    chk({tag, "_re"}, 32'(csr_read_en), 0);
    chk({tag, "_we"}, 32'(csr_write_en), 0);
    chk({tag, "_wd"}, csr_write_data, 0);
  endtask

  task automatic finish_op(input logic [11:0] ea[$], input logic [31:0] ed[$],
                           input logic [31:0] exp_pc, input int lat, input bit busy);
    int n = 1;
    while (redirect_valid !== 1'b1 && n < 20) begin
      chk("busy_stall", 32'(stall), 1);
      mret_valid = busy && n == 2;
      tick();
      n++;
    end
    mret_valid = 1'b0;
    chk("latency", n, lat);
    chk("redir_pc", redirect_pc, exp_pc);
    chk("done_stall", 32'(stall), 1);
    chk("n_writes", log_a.size(), ea.size());
    for (int j = 0; j < ea.size() && j < log_a.size(); j++) begin
      chk("wr_addr", 32'(log_a[j]), 32'(ea[j]));
      chk("wr_data", log_d[j], ed[j]);
    end
    tick();
    chk("pulse_end", 32'(redirect_valid), 0);
    chk("idle_unstall", 32'(stall), 0);
    if (busy) begin
      tick();
      chk("no_2nd_redir", 32'(redirect_valid), 0);
    end
    chk("hold_pc", redirect_pc, exp_pc);
  endtask

  task automatic start_exc(input logic [3:0] c, input logic [31:0] pc, input bit both,
                           output logic [11:0] ea[$], output logic [31:0] ed[$]);
    log_a.delete();
    log_d.delete();
    ea = {};
    ed = {};
    ea.push_back(12'h341); ed.push_back(pc & ~32'h3);
    ea.push_back(12'h342); ed.push_back({28'h0, c});
`ifdef TRAP_SEQ_MTVAL_EN
    exc_tval = $urandom;
    ea.push_back(12'h343); ed.push_back(exc_tval);
`endif
    ea.push_back(12'h300); ed.push_back(trap_status(m_status));
    exc_valid = 1'b1;
    exc_cause = c;
    exc_pc = pc;
    mret_valid = both;
    #1;
    chk("req_stall", 32'(stall), 1);
    tick();
    exc_valid = 1'b0;
    mret_valid = 1'b0;
    exc_pc = $urandom;
    exc_cause = 4'($urandom);
  endtask

  task automatic do_exc(input logic [3:0] c, input logic [31:0] pc, input bit both, input bit busy);
    logic [11:0] ea[$];
    logic [31:0] ed[$];
    logic [31:0] exp_pc = m_tvec & ~32'h3;
    start_exc(c, pc, both, ea, ed);
    finish_op(ea, ed, exp_pc, EXC_LAT, busy);
  endtask

  task automatic do_mret();
    logic [11:0] ea[$];
    logic [31:0] ed[$];
    logic [31:0] exp_pc = m_epc & ~32'h3;
    log_a.delete();
    log_d.delete();
    ea.push_back(12'h300);
    ed.push_back(ret_status(m_status));
    mret_valid = 1'b1;
    #1;
    chk("req_stall", 32'(stall), 1);
    tick();
    mret_valid = 1'b0;
    finish_op(ea, ed, exp_pc, 3, 1'b0);
  endtask

  task automatic do_reset_mid();
    logic [11:0] ea[$];
    logic [31:0] ed[$];
    start_exc(4'd11, 32'h0000_0300, 1'b0, ea, ed);
    for (int n = 1; n < EXC_LAT - 2; n++) tick();
    chk("mid_at_status", 32'(csr_addr), 32'h300);
    reset = 1'b1;
    #1;
    check_all_zero("rst_mid");
    for (int k = 0; k < 3; k++) begin
      tick();
      check_all_zero("rst_hold");
    end
    reset = 1'b0;
    #1;
    check_all_zero("rst_exit");
    chk("rst_redir_pc", redirect_pc, 0);
    chk("rst_n_writes", log_a.size(), EXC_LAT - 3);
    tick();
    check_all_zero("rst_idle");
  endtask

  initial begin
    reset = 1'b1;
    exc_valid = 1'b0;
    mret_valid = 1'b0;
    exc_cause = '0;
    exc_pc = '0;
`ifdef TRAP_SEQ_MTVAL_EN
    exc_tval = '0;
`endif
    m_status = '0; m_epc = '0; m_cause = '0; m_tval = '0; m_tvec = '0;
    for (int k = 0; k < 3; k++) tick();
    check_all_zero("reset");
    chk("reset_redir_pc", redirect_pc, 0);
    reset = 1'b0;
    tick();
    m_status = 32'h0000_0008;
    m_tvec = 32'h0000_0201;
    do_exc(4'd11, 32'h0000_0104, 1'b0, 1'b0);
    chk("ecall_mstatus", m_status, 32'h0000_1880);
    m_epc = 32'h0000_0108;
    do_mret();
    chk("mret_mstatus", m_status, 32'h0000_0088);
    do_exc(4'd2, 32'h0000_0040, 1'b1, 1'b0);
    chk("simul_mcause", m_cause, 2);
    do_exc(4'd3, 32'h0000_0080, 1'b0, 1'b1);
    do_reset_mid();
    do_exc(4'd2, 32'h0000_0444, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      int kind = int'($urandom_range(0, 3));
      m_status = $urandom;
      m_tvec = $urandom;
      if (kind == 2) begin
        m_epc = $urandom;
        do_mret();
      end else
        do_exc(4'($urandom), $urandom, kind == 3, $urandom_range(0, 3) == 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
